// File: rtl/adc_cmd_pkg.sv
// rtl/adc_cmd_pkg.sv - shared constants, state type and command-word helper for the ADC command sequencer
package adc_cmd_pkg;

    localparam int MAX_CH = 8;
    localparam int CMD_W  = 16;

    // ADC control word layout: write flag, 7-bit register address, 8-bit register data
    localparam int CMD_WR_BIT   = 15;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_ADDR_W   = 7;
    localparam int CMD_DATA_LSB = 0;
    localparam int CMD_DATA_W   = 8;

    // 16 SCLK periods at 20 MHz SCLK is 38.4 ti_clk cycles at 48 MHz; rounded up with margin
    localparam logic [15:0] MIN_SAFE_INTERVAL = 16'd40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    function automatic logic [CMD_W-1:0] make_cmd(
        input logic                  wr,
        input logic [CMD_ADDR_W-1:0] addr,
        input logic [CMD_DATA_W-1:0] data
    );
        return {wr, addr, data};
    endfunction

endpackage

// File: rtl/adc_pace_timer.sv
// rtl/adc_pace_timer.sv - loadable 16-bit down-counter pacing command strobes
module adc_pace_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] value,
    output logic        zero
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != 16'd0)) begin
            value_d = value_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 16'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == 16'd0);

endmodule

// File: rtl/adc_cmd_sequencer.sv
// rtl/adc_cmd_sequencer.sv - emits a host-loaded table of ADC command words at a programmable pace
module adc_cmd_sequencer #(
    parameter int MAX_CH = adc_cmd_pkg::MAX_CH,
    parameter int CMD_W  = adc_cmd_pkg::CMD_W
) (
    input  logic             ti_clk,
    input  logic             rst_n,
    input  logic             cfg_wr_en,
    input  logic [2:0]       cfg_addr,
    input  logic [CMD_W-1:0] cfg_data,
    input  logic [3:0]       ch_count,
    input  logic [15:0]      interval,
    input  logic             continuous,
    input  logic             start,
    input  logic             stop,
    output logic [CMD_W-1:0] din,
    output logic             din_en,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    output logic [15:0]      sweep_count
);

    adc_cmd_pkg::seq_state_e state_q, state_d;

    logic [CMD_W-1:0] cmd_tbl_q [MAX_CH];
    logic [CMD_W-1:0] cmd_tbl_d [MAX_CH];
    logic [CMD_W-1:0] din_q, din_d;
    logic             din_en_q, din_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_cfg_q, err_cfg_d;
    logic [15:0]      sweep_count_q, sweep_count_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       ch_last_q, ch_last_d;
    logic [15:0]      reload_q, reload_d;
    logic             cont_q, cont_d;

    logic             pace_load;
    logic             pace_dec;
    logic             pace_zero;
    logic [15:0]      pace_value;
    logic             cfg_legal;
    logic             last_word;

    adc_pace_timer u_pace (
        .clk      (ti_clk),
        .rst_n    (rst_n),
        .load     (pace_load),
        .load_val (reload_q),
        .dec      (pace_dec),
        .value    (pace_value),
        .zero     (pace_zero)
    );

    always_comb begin
        cfg_legal     = (ch_count != 4'd0) && (int'(ch_count) <= MAX_CH);
        last_word     = (idx_q == ch_last_q);
        state_d       = state_q;
        cmd_tbl_d     = cmd_tbl_q;
        din_d         = din_q;
        din_en_d      = 1'b0;
        done_d        = 1'b0;
        err_cfg_d     = 1'b0;
        sweep_count_d = sweep_count_q;
        idx_d         = idx_q;
        ch_last_d     = ch_last_q;
        reload_d      = reload_q;
        cont_d        = cont_q;
        pace_load     = 1'b0;
        pace_dec      = 1'b0;

        case (state_q)
            adc_cmd_pkg::ST_IDLE: begin
                if (cfg_wr_en && (int'(cfg_addr) < MAX_CH)) begin
                    cmd_tbl_d[cfg_addr] = cfg_data;
                end
                // stop wins over a simultaneous start, so nothing is accepted or rejected
                if (start && !stop) begin
                    if (cfg_legal) begin
                        ch_last_d     = 3'(ch_count - 4'd1);
                        reload_d      = (interval == 16'd0) ? 16'd0 : (interval - 16'd1);
                        cont_d        = continuous;
                        idx_d         = 3'd0;
                        sweep_count_d = 16'd0;
                        state_d       = adc_cmd_pkg::ST_EMIT;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            adc_cmd_pkg::ST_EMIT: begin
                din_d     = cmd_tbl_q[idx_q];
                din_en_d  = 1'b1;
                pace_load = 1'b1;
                if (last_word) begin
                    idx_d         = 3'd0;
                    sweep_count_d = sweep_count_q + 16'd1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                if (stop) begin
                    state_d = adc_cmd_pkg::ST_IDLE;
                end else if (last_word && !cont_q) begin
                    state_d = adc_cmd_pkg::ST_DONE;
                end else if (reload_q == 16'd0) begin
                    state_d = adc_cmd_pkg::ST_EMIT;
                end else begin
                    state_d = adc_cmd_pkg::ST_WAIT;
                end
            end
            adc_cmd_pkg::ST_WAIT: begin
                pace_dec = 1'b1;
                // leaving on the last count keeps EMIT-to-EMIT spacing at reload+1 cycles
                if (stop) begin
                    state_d = adc_cmd_pkg::ST_IDLE;
                end else if (pace_zero || (pace_value == 16'd1)) begin
                    state_d = adc_cmd_pkg::ST_EMIT;
                end
            end
            adc_cmd_pkg::ST_DONE: begin
                done_d  = 1'b1;
                state_d = adc_cmd_pkg::ST_IDLE;
            end
            default: begin
                state_d = adc_cmd_pkg::ST_IDLE;
            end
        endcase

        // registered from the next state so busy drops together with the done pulse
        busy_d = (state_d != adc_cmd_pkg::ST_IDLE);
    end

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= adc_cmd_pkg::ST_IDLE;
            din_q         <= '0;
            din_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_cfg_q     <= 1'b0;
            sweep_count_q <= 16'd0;
            idx_q         <= 3'd0;
            ch_last_q     <= 3'd0;
            reload_q      <= 16'd0;
            cont_q        <= 1'b0;
            for (int i = 0; i < MAX_CH; i++) begin
                cmd_tbl_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            din_q         <= din_d;
            din_en_q      <= din_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_cfg_q     <= err_cfg_d;
            sweep_count_q <= sweep_count_d;
            idx_q         <= idx_d;
            ch_last_q     <= ch_last_d;
            reload_q      <= reload_d;
            cont_q        <= cont_d;
            cmd_tbl_q     <= cmd_tbl_d;
        end
    end

    assign din         = din_q;
    assign din_en      = din_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cfg     = err_cfg_q;
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// tb/tb_adc_cmd_sequencer.sv - self-checking bench for adc_cmd_sequencer
module tb_adc_cmd_sequencer;

    localparam int INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [15:0] cfg_data = 16'd0;
    logic [3:0]  ch_count = 4'd0;
    logic [15:0] interval = 16'd0;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] din;
    logic        din_en;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic [15:0] sweep_count;

    int tests = 0;
    int fails = 0;

    adc_cmd_sequencer dut (
        .ti_clk      (clk),
        .rst_n       (rst_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .ch_count    (ch_count),
        .interval    (interval),
        .continuous  (continuous),
        .start       (start),
        .stop        (stop),
        .din         (din),
        .din_en      (din_en),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .sweep_count (sweep_count)
    );

    always #5 clk = ~clk;

    // Reference model: one run described by its start edge and latched parameters
    int          ecount = 0;
    bit          m_active = 0;
    bit          m_cont = 0;
    int          m_start = 0, m_end = 0, m_stop = INF, m_done = -1, m_err = -1;
    int          m_I = 1, m_ch = 1;
    logic [15:0] tbl [8];
    logic [15:0] snap [8];

    function automatic bit m_busy(input int e);
        return m_active && (e >= m_start) && (e < m_end);
    endfunction

    function automatic bit exp_strobe(input int e);
        int t;
        if (!m_active || e < m_start + 1 || e > m_stop) return 1'b0;
        t = e - m_start - 1;
        return ((t % m_I) == 0) && (m_cont || (t / m_I) < m_ch);
    endfunction

    function automatic logic [15:0] exp_word(input int e);
        return snap[((e - m_start - 1) / m_I) % m_ch];
    endfunction

    function automatic logic [15:0] exp_sweep(input int e);
        int ee, n;
        if (!m_active) return 16'd0;
        ee = (e < m_stop) ? e : m_stop;
        if (ee < m_start + 1) return 16'd0;
        n = (ee - m_start - 1) / m_I + 1;
        if (!m_cont && n > m_ch) n = m_ch;
        return 16'((n / m_ch) & 32'hFFFF);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0;
            m_done   = -1;
            m_err    = -1;
            m_stop   = INF;
            for (int i = 0; i < 8; i++) tbl[i] = 16'd0;
        end else begin
            int e;
            bit bp;
            ecount++;
            e  = ecount;
            bp = m_busy(e - 1);
            if (cfg_wr_en && !bp) tbl[cfg_addr] = cfg_data;
            if (!bp) begin
                if (start && !stop) begin
                    if (ch_count >= 4'd1 && ch_count <= 4'd8) begin
                        m_active = 1;
                        m_start  = e;
                        m_ch     = int'(ch_count);
                        m_I      = (interval == 16'd0) ? 1 : int'(interval);
                        m_cont   = continuous;
                        m_stop   = INF;
                        for (int i = 0; i < 8; i++) snap[i] = tbl[i];
                        if (m_cont) begin
                            m_end  = INF;
                            m_done = -1;
                        end else begin
                            m_end  = e + 1 + (m_ch - 1) * m_I + 1;
                            m_done = m_end;
                        end
                    end else begin
                        m_err = e;
                    end
                end
            end else if (stop && e < m_end && e < m_done + (m_done < 0 ? INF : 0)) begin
                m_stop = e;
                m_end  = e;
                m_done = -1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    int          obs_e[$];
    logic [15:0] obs_w[$];
    int          done_n = 0, done_e = -1, err_n = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            int e;
            bit s;
            e = ecount;
            s = exp_strobe(e);
            chk("din_en", din_en, s);
            chk("busy", busy, m_busy(e));
            chk("done", done, (e == m_done));
            chk("err_cfg", err_cfg, (e == m_err));
            chk("sweep_count", sweep_count, exp_sweep(e));
            if (s) chk("din", din, exp_word(e));
            if (din_en) begin
                obs_e.push_back(e);
                obs_w.push_back(din);
            end
            if (done) begin
                done_n++;
                done_e = e;
            end
            if (err_cfg) err_n++;
        end
    end

    task automatic clear_obs();
        obs_e.delete();
        obs_w.delete();
        done_n = 0;
        done_e = -1;
        err_n  = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_start(input int ch, input int iv, input bit cont, output int n);
        @(negedge clk);
        ch_count   = 4'(ch);
        interval   = 16'(iv);
        continuous = cont;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = ecount;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst din_en", din_en, 0);
        chk("rst busy", busy, 0);
        chk("rst sweep", sweep_count, 0);
        chk("rst din", din, 0);
        rst_n = 1'b1;

        // one non-continuous sweep of three words, 40 cycles apart
        wr(0, 16'h1001); wr(1, 16'h1002); wr(2, 16'h1003);
        clear_obs();
        do_start(3, 40, 0, n);
        repeat (90) @(negedge clk);
        chk("t1 strobes", obs_e.size(), 3);
        if (obs_e.size() == 3) begin
            chk("t1 latency", obs_e[0], n + 1);
            chk("t1 gap1", obs_e[1] - obs_e[0], 40);
            chk("t1 gap2", obs_e[2] - obs_e[1], 40);
            chk("t1 w0", obs_w[0], 16'h1001);
            chk("t1 w1", obs_w[1], 16'h1002);
            chk("t1 w2", obs_w[2], 16'h1003);
            chk("t1 done edge", done_e, obs_e[2] + 1);
        end
        chk("t1 done count", done_n, 1);
        chk("t1 sweep", sweep_count, 1);

        // continuous two-word sweep every cycle, stopped after seven words
        clear_obs();
        do_start(2, 1, 1, n);
        repeat (6) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2 strobes", obs_e.size(), 7);
        if (obs_e.size() == 7) begin
            chk("t2 span", obs_e[6] - obs_e[0], 6);
            chk("t2 w1", obs_w[1], 16'h1002);
            chk("t2 w6", obs_w[6], 16'h1001);
        end
        chk("t2 no done", done_n, 0);
        chk("t2 busy", busy, 0);
        chk("t2 sweep", sweep_count, 3);

        // illegal channel counts are rejected
        clear_obs();
        do_start(0, 40, 0, n);
        repeat (3) @(negedge clk);
        do_start(9, 40, 0, n);
        repeat (3) @(negedge clk);
        chk("t3 err count", err_n, 2);
        chk("t3 strobes", obs_e.size(), 0);
        chk("t3 busy", busy, 0);

        // host changes during a run do not affect it
        clear_obs();
        do_start(3, 40, 0, n);
        @(negedge clk);
        interval = 16'd5;
        wr(0, 16'hFFFF);
        repeat (90) @(negedge clk);
        chk("t4 strobes", obs_e.size(), 3);
        if (obs_e.size() == 3) begin
            chk("t4 gap", obs_e[2] - obs_e[1], 40);
            chk("t4 w0", obs_w[0], 16'h1001);
        end
        clear_obs();
        do_start(3, 5, 0, n);
        repeat (15) @(negedge clk);
        chk("t4b strobes", obs_e.size(), 3);
        if (obs_e.size() == 3) begin
            chk("t4b gap", obs_e[1] - obs_e[0], 5);
            chk("t4b w0", obs_w[0], 16'h1001);
        end
        wr(0, 16'hFFFF);
        clear_obs();
        do_start(1, 5, 0, n);
        repeat (4) @(negedge clk);
        chk("t4c strobes", obs_e.size(), 1);
        if (obs_e.size() == 1) chk("t4c w0", obs_w[0], 16'hFFFF);

        // start and stop together while idle
        clear_obs();
        @(negedge clk);
        ch_count = 4'd2;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5 strobes", obs_e.size(), 0);
        chk("t5 err", err_n, 0);
        chk("t5 busy", busy, 0);

        // asynchronous reset in WAIT clears outputs and the table
        clear_obs();
        do_start(1, 3, 1, n);
        repeat (11) @(negedge clk);
        chk("t6 sweep pre", sweep_count, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst din", din, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst sweep", sweep_count, 0);
        chk("t6 rst din_en", din_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        do_start(2, 1, 0, n);
        repeat (5) @(negedge clk);
        chk("t6 strobes", obs_e.size(), 2);
        if (obs_e.size() == 2) begin
            chk("t6 w0", obs_w[0], 16'h0000);
            chk("t6 w1", obs_w[1], 16'h0000);
        end

        // interval 0 streams every cycle; sweep_count wraps
        wr(0, 16'hA5A5);
        clear_obs();
        do_start(1, 0, 1, n);
        repeat (65535) @(negedge clk);
        chk("t7 sweep ffff", sweep_count, 16'hFFFF);
        @(negedge clk);
        chk("t7 sweep wrap", sweep_count, 16'h0000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7 strobes", obs_e.size(), 65537);
        chk("t7 busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_cmd_sequencer.md
# adc_cmd_sequencer

Upstream stage of the ADC interface: runs on `ti_clk` and produces the 16-bit ADC command words that feed the interface's `din`/`din_en` input. It holds a host-loaded table of up to 8 command words, emits them in order (one sweep), and optionally repeats sweeps continuously. Words are spaced by a programmable interval so the shallow 4-word command FIFO downstream, drained at SCLK/16 words per cycle, never overflows.

## Interface
Parameters:
- `MAX_CH`, 8, table depth and maximum channels per sweep.
- `CMD_W`, 16, command word width; must equal the interface `din` width.

Ports:
- `ti_clk` in 1: host-side clock (48 MHz); the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_wr_en` in 1: write `cfg_data` into table entry `cfg_addr`.
- `cfg_addr` in 3: table index.
- `cfg_data` in 16: command word.
- `ch_count` in 4: words per sweep; legal range 1..MAX_CH.
- `interval` in 16: `ti_clk` cycles between consecutive `din_en` pulses; 0 is treated as 1.
- `continuous` in 1: 1 = repeat sweeps until `stop`; 0 = one sweep.
- `start` in 1: single-cycle start request.
- `stop` in 1: single-cycle abort request.
- `din` out 16: command word to the ADC interface.
- `din_en` out 1: single-cycle write strobe for `din`.
- `busy` out 1: high in EMIT/WAIT.
- `done` out 1: single-cycle pulse when a non-continuous sweep completes.
- `err_cfg` out 1: single-cycle pulse when `start` is rejected.
- `sweep_count` out 16: completed sweeps since the last accepted `start`.

## Operation
- State machine: IDLE, EMIT, WAIT, DONE.
- IDLE:
  - `start` with `ch_count` in 1..MAX_CH: latch `ch_count`, `interval` and `continuous` into shadow registers; clear `idx` and `sweep_count`; go to EMIT.
  - `start` with illegal `ch_count` (0 or >MAX_CH): pulse `err_cfg`; stay in IDLE.
- EMIT (1 cycle): register `din = table[idx]` and pulse `din_en`. Load the pace counter with `max(interval,1)-1`.
  - If `idx == ch_count-1`: `idx` wraps to 0 and `sweep_count` increments (wraps 0xFFFF->0).
  - Last word and non-continuous: go to DONE.
  - Otherwise: go to WAIT, or straight back to EMIT when the loaded count is 0.
- WAIT: decrement the pace counter; at 0, go to EMIT.
- DONE: pulse `done`; go to IDLE.
- `stop` in EMIT or WAIT: the word emitted in that cycle (if any) still goes out; next state is IDLE; no `done` pulse.
- `stop` has priority over `start` in the same cycle. `start` while busy is ignored.
- Table writes (`cfg_wr_en`):
  - Accepted only in IDLE; ignored otherwise.
  - Shadowed parameters do not change mid-run; host changes to `ch_count`, `interval` or `continuous` take effect at the next `start`.
- Reset (asynchronous): state IDLE; `din`=0, `din_en`=0, `busy`=0, `done`=0, `err_cfg`=0, `sweep_count`=0; all table entries 0.

## Timing
- Latency: `start` sampled high at edge N gives the first `din_en` at edge N+1.
- Consecutive `din_en` pulses are exactly `max(interval,1)` cycles apart, including across sweep boundaries.
- Final word:
  - `done` asserts the cycle after the last `din_en`.
  - `busy` falls in that same cycle.
  - `sweep_count` is already updated in that cycle.
- `din` holds its value between strobes; it is valid only while `din_en` = 1.
- `err_cfg` asserts the cycle after the rejected `start`.
- Reset asserted mid-sweep clears all outputs immediately; no partial strobe.

## Structure
- Shared package `adc_cmd_pkg`:
  - `MAX_CH` and `CMD_W`.
  - Command-word field constants (register address and data fields of the ADC control word).
  - Minimum safe interval constant: 16 SCLK periods expressed in `ti_clk` cycles at the highest SCLK (20 MHz gives 39 cycles; use 40).
- One sub-module, `adc_pace_timer`: loadable 16-bit down-counter with `load`, `value` and `zero` ports, reused for the WAIT countdown.

## Test plan
- Load table {0x1001,0x1002,0x1003}, `ch_count`=3, `interval`=40, `continuous`=0, pulse `start` -> three `din_en` 40 cycles apart with those words in order; `done` one cycle after the third; `sweep_count`=1.
- `continuous`=1, `ch_count`=2, `interval`=1 -> `din_en` every cycle alternating table[0]/table[1]; `stop` after 7 words -> exactly 7 strobes, `busy`=0, no `done`, `sweep_count`=3.
- `ch_count`=0, then `ch_count`=9, each with `start` -> `err_cfg` pulse each time; no `din_en`; state stays IDLE.
- Mid-sweep: change `interval` to 5 and write table[0]=0xFFFF -> spacing and words unchanged for the current run; new values used after the next `start`.
- `start` and `stop` in the same cycle while IDLE -> nothing happens. Deassert `rst_n` during WAIT -> all outputs 0 asynchronously and table cleared.
- `interval`=0 with `ch_count`=1 and `continuous`=1 -> `din_en` every cycle; `sweep_count` counts 0xFFFF then 0x0000.
